// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
// Produces the slow CPU clock from the 50 MHz board clock. It supports three
// modes: free-running divided clock, pause, and single-step from a debounced
// push button. A pause request never shortens a high phase, so cpu_clk has no
// runt pulses. The block also counts cpu_clk rising edges for the LCD.
//
// Ports:
//   clk          board clock (CLOCK_50)
//   reset        synchronous, active-high reset
//   pause        asynchronous level, 1 = request pause
//   step_btn     asynchronous raw step button, active-high
//   cpu_clk      registered slow clock to the cpu
//   cpu_rise     one-clk pulse coincident with each cpu_clk 0->1 transition
//   paused       1 while in PAUSED, STEP_HIGH or STEP_LOW
//   cycle_count  cpu_clk rising edges since reset, wraps
module cpu_clock_ctrl #(
    parameter int DIV_BITS   = 25,
    parameter int STEP_BITS  = 20,
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pause,
    input  logic                step_btn,
    output logic                cpu_clk,
    output logic                cpu_rise,
    output logic                paused,
    output logic [CNT_BITS-1:0] cycle_count
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        PAUSED    = 2'd1,
        STEP_HIGH = 2'd2,
        STEP_LOW  = 2'd3
    } state_e;

    logic                 pause_s1_q, pause_s2_q;
    logic                 step_s1_q, step_s2_q;
    logic                 deb_level_q, deb_level_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic                 step_req_q, step_req_d;
    state_e               state_q, state_d;
    logic [DIV_BITS-1:0]  div_q, div_d;
    logic [STEP_BITS-1:0] tmr_q, tmr_d;
    logic                 cpu_clk_q, cpu_clk_d;
    logic                 rise_q, rise_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_s1_q  <= 1'b0;
            pause_s2_q  <= 1'b0;
            step_s1_q   <= 1'b0;
            step_s2_q   <= 1'b0;
            deb_level_q <= 1'b0;
            deb_cnt_q   <= '0;
            step_req_q  <= 1'b0;
            state_q     <= RUN;
            div_q       <= '0;
            tmr_q       <= '0;
            cpu_clk_q   <= 1'b0;
            rise_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pause_s1_q  <= pause;
            pause_s2_q  <= pause_s1_q;
            step_s1_q   <= step_btn;
            step_s2_q   <= step_s1_q;
            deb_level_q <= deb_level_d;
            deb_cnt_q   <= deb_cnt_d;
            step_req_q  <= step_req_d;
            state_q     <= state_d;
            div_q       <= div_d;
            tmr_q       <= tmr_d;
            cpu_clk_q   <= cpu_clk_d;
            rise_q      <= rise_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        deb_level_d = deb_level_q;
        deb_cnt_d   = deb_cnt_q;
        step_req_d  = 1'b0;
        state_d     = state_q;
        div_d       = div_q;
        tmr_d       = tmr_q;
        cpu_clk_d   = cpu_clk_q;
        rise_d      = 1'b0;
        cnt_d       = cnt_q;

        // Debounce: the level flips only after DEB_CYCLES consecutive
        // disagreeing samples; any agreeing sample restarts the count.
        if (step_s2_q != deb_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_level_d = step_s2_q;
                deb_cnt_d   = '0;
                step_req_d  = step_s2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end

        case (state_q)
            RUN: begin
                if (pause_s2_q && !cpu_clk_q) begin
                    state_d = PAUSED;
                    div_d   = '0;
                end else if (div_q == '1) begin
                    div_d     = '0;
                    cpu_clk_d = ~cpu_clk_q;
                    rise_d    = ~cpu_clk_q;
                    // Reaching here with pause set means cpu_clk was high,
                    // so this is the natural falling edge: stop on it.
                    if (pause_s2_q) begin
                        state_d = PAUSED;
                    end
                end else begin
                    div_d = div_q + DIV_BITS'(1);
                end
            end
            PAUSED: begin
                cpu_clk_d = 1'b0;
                div_d     = '0;
                // Resume wins over a step request arriving in the same cycle.
                if (!pause_s2_q) begin
                    state_d = RUN;
                end else if (step_req_q) begin
                    cpu_clk_d = 1'b1;
                    rise_d    = 1'b1;
                    tmr_d     = '0;
                    state_d   = STEP_HIGH;
                end
            end
            STEP_HIGH: begin
                if (tmr_q == '1) begin
                    cpu_clk_d = 1'b0;
                    tmr_d     = '0;
                    state_d   = STEP_LOW;
                end else begin
                    tmr_d = tmr_q + STEP_BITS'(1);
                end
            end
            STEP_LOW: begin
                if (tmr_q == '1) begin
                    state_d = PAUSED;
                end else begin
                    tmr_d = tmr_q + STEP_BITS'(1);
                end
            end
            default: state_d = RUN;
        endcase

        if (rise_d) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign cpu_rise    = rise_q;
    assign paused      = (state_q != RUN);
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
module tb_cpu_clock_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       pause;
    logic       step_btn;
    logic       cpu_clk;
    logic       cpu_rise;
    logic       paused;
    logic [3:0] cycle_count;

    cpu_clock_ctrl #(
        .DIV_BITS  (3),
        .STEP_BITS (2),
        .DEB_CYCLES(4),
        .CNT_BITS  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pause      (pause),
        .step_btn   (step_btn),
        .cpu_clk    (cpu_clk),
        .cpu_rise   (cpu_rise),
        .paused     (paused),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Number of rising clk edges so far; read on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic step_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_rise(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every cpu_rise pulse must match the next scheduled rise.
    always @(negedge clk) begin
        if (cpu_rise === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rise at cyc %0d: count %0d, no rise expected", cyc, cycle_count);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rise_cycle", cyc, e.cyc);
                check("rise_count", int'(cycle_count), e.cnt);
                check("rise_cpu_clk", int'(cpu_clk), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    int r, t, p;

    initial begin
        reset    = 1'b1;
        pause    = 1'b0;
        step_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cpu_clk", int'(cpu_clk), 0);
        check("rst_cpu_rise", int'(cpu_rise), 0);
        check("rst_paused", int'(paused), 0);
        check("rst_count", int'(cycle_count), 0);

        // Free-run
        r = cyc;
        reset = 1'b0;
        expect_rise(r + 8, 1);
        expect_rise(r + 24, 2);
        expect_rise(r + 40, 3);
        expect_rise(r + 56, 4);
        step_to(r + 7);
        check("run_pre_rise", int'(cpu_clk), 0);
        step_to(r + 16);
        check("run_fall", int'(cpu_clk), 0);
        step_to(r + 48);
        check("run_count48", int'(cycle_count), 3);
        check("run_paused", int'(paused), 0);

        // Pause while cpu_clk high: the high phase completes
        step_to(r + 58);
        pause = 1'b1;
        step_to(r + 63);
        check("pause_hold_high", int'(cpu_clk), 1);
        check("pause_not_yet", int'(paused), 0);
        step_to(r + 64);
        check("pause_fall", int'(cpu_clk), 0);
        check("pause_entered", int'(paused), 1);
        step_to(r + 164);
        check("pause_idle_clk", int'(cpu_clk), 0);
        check("pause_idle_paused", int'(paused), 1);
        check("pause_idle_count", int'(cycle_count), 4);

        // Single step, 10-clk press
        t = cyc;
        step_btn = 1'b1;
        expect_rise(t + 7, 5);
        step_to(t + 6);
        check("step_pre", int'(cpu_clk), 0);
        step_to(t + 7);
        check("step_high_start", int'(cpu_clk), 1);
        step_to(t + 10);
        check("step_high_end", int'(cpu_clk), 1);
        step_btn = 1'b0;
        step_to(t + 11);
        check("step_low_start", int'(cpu_clk), 0);
        step_to(t + 14);
        check("step_low_paused", int'(paused), 1);
        step_to(t + 20);

        // Second press debounced while still in the step low phase is dropped
        t = cyc;
        step_btn = 1'b1;
        expect_rise(t + 7, 6);
        step_to(t + 4);
        step_btn = 1'b0;
        step_to(t + 8);
        step_btn = 1'b1;
        step_to(t + 11);
        check("dbl_fall", int'(cpu_clk), 0);
        step_to(t + 20);
        step_btn = 1'b0;
        step_to(t + 30);
        check("dbl_count", int'(cycle_count), 6);
        check("dbl_cpu_clk", int'(cpu_clk), 0);

        // Bounce: toggle every 2 clk for 20 clk
        for (int i = 0; i < 10; i++) begin
            step_btn = (i % 2 == 0);
            repeat (2) @(negedge clk);
        end
        step_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("bounce_count", int'(cycle_count), 6);
        check("bounce_cpu_clk", int'(cpu_clk), 0);
        check("bounce_paused", int'(paused), 1);

        // Resume coinciding with a step request: resume wins
        t = cyc;
        step_btn = 1'b1;
        expect_rise(t + 15, 7);
        step_to(t + 4);
        pause = 1'b0;
        step_to(t + 6);
        check("resume_still_paused", int'(paused), 1);
        step_to(t + 7);
        check("resume_paused", int'(paused), 0);
        check("resume_no_step", int'(cpu_clk), 0);
        step_to(t + 12);
        step_btn = 1'b0;
        step_to(t + 16);
        pause = 1'b1;
        step_to(t + 24);
        check("repause_paused", int'(paused), 1);
        check("repause_clk", int'(cpu_clk), 0);

        // Reset in STEP_HIGH
        p = cyc;
        step_btn = 1'b1;
        expect_rise(p + 7, 8);
        step_to(p + 8);
        check("sh_high", int'(cpu_clk), 1);
        reset    = 1'b1;
        pause    = 1'b0;
        step_btn = 1'b0;
        step_to(p + 9);
        check("sh_rst_clk", int'(cpu_clk), 0);
        check("sh_rst_count", int'(cycle_count), 0);
        check("sh_rst_paused", int'(paused), 0);
        check("sh_rst_rise", int'(cpu_rise), 0);

        // Counter wrap over 16 periods
        r = cyc;
        reset = 1'b0;
        for (int k = 0; k < 16; k++) expect_rise(r + 8 + 16 * k, (k + 1) % 16);
        step_to(r + 8 + 16 * 14 + 1);
        check("wrap_15", int'(cycle_count), 15);
        step_to(r + 8 + 16 * 15 + 1);
        check("wrap_0", int'(cycle_count), 0);
        step_to(r + 250);
        check("pending_rises", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
